pmem_router: RTL and testbench

- Pipelined Wishbone router between the CPU core's program-memory master port and two program-memory slaves: main program region and exception-handler region.
- Decodes the address region of each request and steers the request strobe to the matching slave.
- Tracks outstanding transactions so responses always return in issue order; stalls the master when a new request targets a different slave than the in-flight ones.
- Replaces ad-hoc pmem multiplexing and serves both simulation and synthesis tops.

---
 rtl/pmem_pkg.sv | 30 +++
 rtl/pmem_out_cnt.sv | 43 ++++
 rtl/pmem_router.sv | 113 +++++++++++
 tb/tb_pmem_router.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pmem_pkg.sv
// Shared definitions for the program-memory router.
//   - owner / target encodings (S0 main program, S1 exception handler, UNM unmapped)
//   - default address-region codes for adr[31:28]
//   - slave word-address width
//   - decode_tgt(): region code -> target encoding
package pmem_pkg;

   localparam logic [1:0] OWN_S0  = 2'd0;
   localparam logic [1:0] OWN_S1  = 2'd1;
   localparam logic [1:0] OWN_UNM = 2'd2;

   localparam logic [3:0] S0_REGION_DEF = 4'hB;
   localparam logic [3:0] S1_REGION_DEF = 4'h8;

   localparam int SADR_W = 13;

   // Unmapped regions fall back to S0 unless the error response is built in.
   function automatic logic [1:0] decode_tgt(input logic [3:0] region,
                                             input logic [3:0] s0_region,
                                             input logic [3:0] s1_region,
                                             input logic       unm_en);
      logic [1:0] tgt;
      if (region == s0_region)      tgt = OWN_S0;
      else if (region == s1_region) tgt = OWN_S1;
      else if (unm_en)              tgt = OWN_UNM;
      else                          tgt = OWN_S0;
      return tgt;
   endfunction

endpackage

// File: rtl/pmem_out_cnt.sv
// Saturating counter of accepted-but-unanswered requests.
// Ports:
//   clk_i, rst_i   clock, asynchronous active-low reset
//   inc_i          request accepted this cycle
//   dec_i          response delivered this cycle
//   clr_i          drop everything outstanding (cycle abort); wins over inc/dec
//   zero_o         nothing outstanding
//   full_o         MAX_OUT requests outstanding
module pmem_out_cnt #(
   parameter int CNT_W   = 3,
   parameter int MAX_OUT = 3
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic inc_i,
   input  logic dec_i,
   input  logic clr_i,
   output logic zero_o,
   output logic full_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign zero_o = (cnt_q == '0);
   assign full_o = (cnt_q == CNT_W'(MAX_OUT));

   // Simultaneous inc and dec cancel out.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (inc_i && !dec_i && !full_o)
         cnt_d = cnt_q + CNT_W'(1);
      else if (dec_i && !inc_i && !zero_o)
         cnt_d = cnt_q - CNT_W'(1);
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/pmem_router.sv
// Pipelined Wishbone router: CPU program-memory master -> main program slave (s0)
// and exception-handler slave (s1). Zero-cycle combinational routing; responses
// return in issue order because all in-flight requests share one owner slave.
// Ports:
//   clk_i, rst_i               clock, asynchronous active-low reset
//   m_cyc_i/m_stb_i/m_adr_i    master request, m_adr_i holds byte address bits [31:2]
//   m_stall_o/m_ack_o/m_dat_o  master response
//   m_err_o                    error response (only with PMEM_ROUTER_ERR_EN)
//   sX_cyc_o/sX_stb_o/sX_adr_o slave request, sX_adr_o is byte address bits [14:2]
//   sX_stall_i/sX_ack_i/sX_dat_i slave response
// Build option PMEM_ROUTER_ERR_EN: unmapped addresses get a one-cycle error
// response instead of being routed to s0.
module pmem_router
   import pmem_pkg::*;
#(
   parameter logic [3:0] S0_REGION = S0_REGION_DEF,
   parameter logic [3:0] S1_REGION = S1_REGION_DEF,
   parameter int         MAX_OUT   = 3,
   parameter int         CNT_W     = 3
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              m_cyc_i,
   input  logic              m_stb_i,
   input  logic [29:0]       m_adr_i,
   output logic              m_stall_o,
   output logic              m_ack_o,
   output logic [31:0]       m_dat_o,
`ifdef PMEM_ROUTER_ERR_EN
   output logic              m_err_o,
`endif
   output logic              s0_cyc_o,
   output logic              s0_stb_o,
   output logic [SADR_W-1:0] s0_adr_o,
   input  logic              s0_stall_i,
   input  logic              s0_ack_i,
   input  logic [31:0]       s0_dat_i,
   output logic              s1_cyc_o,
   output logic              s1_stb_o,
   output logic [SADR_W-1:0] s1_adr_o,
   input  logic              s1_stall_i,
   input  logic              s1_ack_i,
   input  logic [31:0]       s1_dat_i
);

`ifdef PMEM_ROUTER_ERR_EN
   localparam logic UNM_EN = 1'b1;
`else
   localparam logic UNM_EN = 1'b0;
`endif

   logic [1:0] tgt;
   logic [1:0] owner_q, owner_d;
   logic       req, allowed, accept;
   logic       ack, err_rsp, rsp;
   logic       cnt_zero, cnt_full;
   logic       unused_adr;

   assign tgt = decode_tgt(m_adr_i[29:26], S0_REGION, S1_REGION, UNM_EN);
   assign req = m_cyc_i & m_stb_i;

   // An unmapped request may only start from an empty pipeline; without the
   // error option tgt never decodes to UNM and that term is always true.
   assign allowed = (cnt_zero | (tgt == owner_q)) & !cnt_full &
                    ((tgt != OWN_UNM) | cnt_zero);

   assign s0_stb_o  = req & (tgt == OWN_S0) & allowed;
   assign s1_stb_o  = req & (tgt == OWN_S1) & allowed;
   assign m_stall_o = !allowed | ((tgt == OWN_S0) & s0_stall_i) |
                                 ((tgt == OWN_S1) & s1_stall_i);
   assign accept    = req & !m_stall_o;

   // Only the owner's ack counts, and only while something is outstanding.
   assign ack     = !cnt_zero & (((owner_q == OWN_S0) & s0_ack_i) |
                                 ((owner_q == OWN_S1) & s1_ack_i));
   // An accepted unmapped request answers itself one cycle later.
   assign err_rsp = !cnt_zero & (owner_q == OWN_UNM);
   assign rsp     = ack | err_rsp;

   assign m_ack_o = ack;
   assign m_dat_o = (owner_q == OWN_S1) ? s1_dat_i : s0_dat_i;
`ifdef PMEM_ROUTER_ERR_EN
   assign m_err_o = err_rsp;
`endif

   assign s0_cyc_o = m_cyc_i;
   assign s1_cyc_o = m_cyc_i;
   assign s0_adr_o = m_adr_i[SADR_W-1:0];
   assign s1_adr_o = m_adr_i[SADR_W-1:0];

   assign unused_adr = ^m_adr_i[25:SADR_W];

   assign owner_d = accept ? tgt : owner_q;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) owner_q <= OWN_S0;
      else        owner_q <= owner_d;
   end

   pmem_out_cnt #(
      .CNT_W   (CNT_W),
      .MAX_OUT (MAX_OUT)
   ) u_out_cnt (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .inc_i  (accept),
      .dec_i  (rsp),
      .clr_i  (!m_cyc_i),
      .zero_o (cnt_zero),
      .full_o (cnt_full)
   );

endmodule

// File: tb/tb_pmem_router.sv
module tb_pmem_router;

   localparam logic [31:0] S0_BASE = 32'h5000_0000;
   localparam logic [31:0] S1_BASE = 32'h6100_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        m_cyc, m_stb;
   logic [29:0] m_adr;
   logic        m_stall_o, m_ack_o;
   logic [31:0] m_dat_o;
   logic        err_w;
   logic        s0_cyc_o, s0_stb_o, s1_cyc_o, s1_stb_o;
   logic [12:0] s0_adr_o, s1_adr_o;
   logic        s0_stall, s1_stall;
   logic        s0_ack_m, s1_ack_m, spur0, spur1;
   logic [31:0] s0_dat_m, s1_dat_m;
   logic        s0_ack_i, s1_ack_i;

   assign s0_ack_i = s0_ack_m | spur0;
   assign s1_ack_i = s1_ack_m | spur1;

   pmem_router dut (
      .clk_i      (clk),
      .rst_i      (rst_n),
      .m_cyc_i    (m_cyc),
      .m_stb_i    (m_stb),
      .m_adr_i    (m_adr),
      .m_stall_o  (m_stall_o),
      .m_ack_o    (m_ack_o),
      .m_dat_o    (m_dat_o),
`ifdef PMEM_ROUTER_ERR_EN
      .m_err_o    (err_w),
`endif
      .s0_cyc_o   (s0_cyc_o),
      .s0_stb_o   (s0_stb_o),
      .s0_adr_o   (s0_adr_o),
      .s0_stall_i (s0_stall),
      .s0_ack_i   (s0_ack_i),
      .s0_dat_i   (s0_dat_m),
      .s1_cyc_o   (s1_cyc_o),
      .s1_stb_o   (s1_stb_o),
      .s1_adr_o   (s1_adr_o),
      .s1_stall_i (s1_stall),
      .s1_ack_i   (s1_ack_i),
      .s1_dat_i   (s1_dat_m)
   );

`ifndef PMEM_ROUTER_ERR_EN
   assign err_w = 1'b0;
`endif

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- scoreboard ----------------
   typedef struct {
      logic        err;
      logic [31:0] dat;
   } exp_t;
   exp_t exp_q[$];
   int   eseq0 = 0;
   int   eseq1 = 0;

   always @(negedge clk) begin
      exp_t e;
      if (m_ack_o === 1'b1 || err_w === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("m_ack_o with nothing outstanding", {31'b0, m_ack_o}, 32'd0);
`ifdef PMEM_ROUTER_ERR_EN
            check("m_err_o with nothing outstanding", {31'b0, err_w}, 32'd0);
`endif
         end else begin
            e = exp_q.pop_front();
            check("m_ack_o vs response kind", {31'b0, m_ack_o}, {31'b0, !e.err});
`ifdef PMEM_ROUTER_ERR_EN
            check("m_err_o vs response kind", {31'b0, err_w}, {31'b0, e.err});
`endif
            if (!e.err) check("m_dat_o in order", m_dat_o, e.dat);
         end
      end
   end

   // ---------------- slave models ----------------
   int lat0 = 1, lat1 = 1;
   int cyc  = 0;
   int seq0 = 0, seq1 = 0;
   int due0[$], due1[$];
   logic [31:0] d0[$], d1[$];
   logic a0_n = 1'b0, a1_n = 1'b0;

   initial begin
      s0_ack_m = 1'b0; s1_ack_m = 1'b0;
      s0_dat_m = 32'hDEAD_0000; s1_dat_m = 32'hDEAD_0001;
   end

   always @(negedge clk) begin
      a0_n = s0_stb_o & !s0_stall;
      a1_n = s1_stb_o & !s1_stall;
   end

   always @(posedge clk) begin
      #1;
      cyc++;
      if (s0_ack_m) begin void'(due0.pop_front()); void'(d0.pop_front()); end
      if (s1_ack_m) begin void'(due1.pop_front()); void'(d1.pop_front()); end
      if (a0_n) begin due0.push_back(cyc + lat0 - 1); d0.push_back(S0_BASE | seq0); seq0++; end
      if (a1_n) begin due1.push_back(cyc + lat1 - 1); d1.push_back(S1_BASE | seq1); seq1++; end
      s0_ack_m = (due0.size() > 0) && (due0[0] <= cyc);
      s1_ack_m = (due1.size() > 0) && (due1[0] <= cyc);
      s0_dat_m = (d0.size() > 0) ? d0[0] : 32'hDEAD_0000;
      s1_dat_m = (d1.size() > 0) ? d1[0] : 32'hDEAD_0001;
   end

   // ---------------- stimulus ----------------
   // Expected destination of a byte address: 0 = s0, 1 = s1, 2 = error.
   function automatic int tgt_of(input logic [31:0] ba);
      case (ba[31:28])
         4'hB:    return 0;
         4'h8:    return 1;
`ifdef PMEM_ROUTER_ERR_EN
         default: return 2;
`else
         default: return 0;
`endif
      endcase
   endfunction

   task automatic issue(input logic [31:0] ba, input int exp_stalls);
      int   t;
      int   stalls;
      logic got;
      exp_t e;
      t      = tgt_of(ba);
      stalls = 0;
      got    = 1'b0;
      m_cyc  = 1'b1;
      m_stb  = 1'b1;
      m_adr  = ba[31:2];
      while (!got && stalls < 64) begin
         @(negedge clk);
         if (m_stall_o === 1'b0) got = 1'b1;
         else stalls++;
      end
      if (!got) begin
         n_vec++; n_bad++;
         $display("FAIL accept timeout %h: still stalled after %0d cycles, required accept", ba, stalls);
      end else begin
         check($sformatf("stall cycles %h", ba), stalls, exp_stalls);
         check($sformatf("s0_stb_o %h", ba), {31'b0, s0_stb_o}, {31'b0, t == 0});
         check($sformatf("s1_stb_o %h", ba), {31'b0, s1_stb_o}, {31'b0, t == 1});
         e.err = (t == 2);
         e.dat = (t == 1) ? (S1_BASE | eseq1) : (S0_BASE | eseq0);
         if (t == 0) eseq0++;
         if (t == 1) eseq1++;
         exp_q.push_back(e);
      end
      @(posedge clk); #1;
      m_stb = 1'b0;
   endtask

   task automatic idle(input int n);
      m_stb = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin @(posedge clk); n++; end
      idle(8);
      check("scoreboard drained", exp_q.size(), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; m_cyc = 1'b0; m_stb = 1'b0; m_adr = '0;
      s0_stall = 1'b0; s1_stall = 1'b0; spur0 = 1'b0; spur1 = 1'b0;
      @(negedge clk);
      check("reset m_ack_o",   {31'b0, m_ack_o},   32'd0);
      check("reset s0_stb_o",  {31'b0, s0_stb_o},  32'd0);
      check("reset s1_stb_o",  {31'b0, s1_stb_o},  32'd0);
      check("reset m_stall_o", {31'b0, m_stall_o}, 32'd0);
`ifdef PMEM_ROUTER_ERR_EN
      check("reset m_err_o",   {31'b0, err_w},     32'd0);
`endif
      @(posedge clk); #1;
      rst_n = 1'b1;
      m_cyc = 1'b1;
      idle(2);

      // back-to-back zero-wait reads
      lat0 = 1;
      issue(32'hB000_0000, 0);
      issue(32'hB000_0004, 0);
      issue(32'hB000_0008, 0);
      drain();

      // outstanding limit
      lat0 = 4;
      issue(32'hB000_0000, 0);
      issue(32'hB000_0004, 0);
      issue(32'hB000_0008, 0);
      issue(32'hB000_000C, 2);
      drain();

      // target switch waits for the pipeline to empty
      issue(32'hB000_0010, 0);
      issue(32'h8000_0000, 4);
      drain();

      // acks from a non-owner, and any ack with nothing outstanding
      issue(32'hB000_0020, 0);
      issue(32'hB000_0024, 0);
      spur1 = 1'b1;
      @(negedge clk);
      check("non-owner ack blocked", {31'b0, m_ack_o}, 32'd0);
      @(posedge clk); #1;
      spur1 = 1'b0;
      drain();
      spur0 = 1'b1;
      @(negedge clk);
      check("idle ack blocked", {31'b0, m_ack_o}, 32'd0);
      @(posedge clk); #1;
      spur0 = 1'b0;

      // cycle abort with two outstanding
      issue(32'hB000_0030, 0);
      issue(32'hB000_0034, 0);
      m_cyc = 1'b0;
      exp_q.delete();
      @(posedge clk); #1;
      issue(32'h8000_0004, 0);
      drain();

      // slave stall
      lat0 = 1;
      s0_stall = 1'b1;
      fork
         issue(32'hB000_0100, 2);
         begin @(posedge clk); @(posedge clk); #1; s0_stall = 1'b0; end
      join
      drain();

      // unmapped address
`ifdef PMEM_ROUTER_ERR_EN
      issue(32'h4000_0000, 0);
      @(negedge clk);
      check("m_err_o pulse", {31'b0, err_w}, 32'd1);
      @(negedge clk);
      check("m_err_o one cycle", {31'b0, err_w}, 32'd0);
      @(posedge clk); #1;
      issue(32'h4000_0000, 0);
      issue(32'h4000_0008, 1);
      issue(32'hB000_0000, 1);
      drain();
`else
      issue(32'h4000_0000, 0);
      drain();
`endif

      // reset while a read is outstanding; the late ack must be dropped
      lat0 = 4;
      issue(32'hB000_0040, 0);
      rst_n = 1'b0;
      m_cyc = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check("reset mid-transfer m_ack_o", {31'b0, m_ack_o}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      m_cyc = 1'b1;
      idle(8);
      lat0 = 1;
      issue(32'hB000_0044, 0);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
